pcie_ptm_tlp_detector: RTL and testbench
========================================

PCIE_PTM_TLP_DETECTOR -- requirements
Module: pcie_ptm_tlp_detector

Interface
REQ-001 SHALL have port clk_in, input, 1, the single clock for all logic, the same symbol clock the sniffer tap forwards.
REQ-002 SHALL have port rst_n_in, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rx_data_in, input, 16, the symbol pair; lane 0 = bits 7:0, earlier in time; lane 1 = bits 15:8.
REQ-004 SHALL have port rx_ctl_in, input, 2, the K-flag per lane; bit i set means lane i carries a K symbol.
REQ-005 SHALL have port ptm_req_valid, output, 1, a one-cycle pulse for a good PTM Request.
REQ-006 SHALL have port ptm_rsp_valid, output, 1, a one-cycle pulse for a good PTM Response without data.
REQ-007 SHALL have port ptm_rspd_valid, output, 1, a one-cycle pulse for a good PTM ResponseD.
REQ-008 SHALL have port ptm_master_time, output, 64, the master time from the last ResponseD.
REQ-009 SHALL have port ptm_prop_delay, output, 32, the propagation delay from the last ResponseD.
REQ-010 SHALL have port ptm_sof_stamp, output, 32, the cycle-counter value at the STP of the last reported TLP.
REQ-011 SHALL have port ptm_err, output, 1, a one-cycle pulse for a malformed PTM TLP.

Function
REQ-012 SHALL process both lanes each cycle in lane order, with lane 0 before lane 1.
REQ-013 SHALL define the byte index from STP (K, 0xFB) as follows: index 0 = STP; 1-2 = sequence; 3-18 = header; 19-26 = payload; then LCRC; then END (K, 0xFD).
REQ-014 SHALL accept STP in either lane; when STP is in lane 1, lane 0 of the next cycle SHALL be index 1.
REQ-015 SHALL use FSM states IDLE, HDR, DATA and SKIP.
- IDLE -> HDR on STP.
- HDR -> DATA after index 18 when the TLP is a ResponseD.
- HDR or DATA -> SKIP on a non-PTM TLP.
- SKIP -> IDLE on END, on EDB, or on the 4096-byte limit.
REQ-016 SHALL classify a TLP as PTM only when the message code at index 10 is 0x52 or 0x53.
- Index 3 = 0x34 with code 0x52 is Request.
- Index 3 = 0x34 with code 0x53 is Response.
- Index 3 = 0x74 with code 0x53 is ResponseD.
- Any other combination SHALL be ignored silently.
REQ-017 SHALL expect END at index 23 for Request/Response and at index 31 for ResponseD.
REQ-018 SHALL, on END at the expected index, pulse the matching valid signal on the clock edge following the cycle that carries END.
REQ-019 SHALL pulse ptm_err once and return to IDLE when a PTM-classified TLP has END at any other index or has a 4096-byte overrun.
REQ-020 SHALL assemble ptm_prop_delay from indices 15-18, big-endian.
REQ-021 SHALL assemble ptm_master_time[31:0] from indices 19-22 and [63:32] from indices 23-26, each big-endian.
REQ-022 SHALL update ptm_master_time and ptm_prop_delay only in the same edge as ptm_rspd_valid, and SHALL otherwise hold them.
REQ-023 SHALL, on EDB (K, 0xFE), discard the TLP with no valid and no error, and return to IDLE.
REQ-024 SHALL, on STP while not IDLE, abort the current TLP, pulse ptm_err if it was PTM-classified, and start a new TLP at that STP in the same cycle.
REQ-025 SHALL, when END and STP share one cycle (END lane 0, STP lane 1), complete the first TLP and start the second with no loss.
REQ-026 SHALL never assert more than one of the valid pulses or ptm_err in the same cycle.

Reset
REQ-027 SHALL, while rst_n_in is low, force all outputs to 0, the FSM to IDLE, and the counters to 0, immediately and independent of clk_in.
REQ-028 SHALL, on reset mid-TLP, drop the TLP and produce no pulse after release; detection SHALL resume at the next STP.

Configuration
REQ-029 SHALL, with macro PTM_SNIFF_TIMESTAMP_EN defined, include a free-running 32-bit cycle counter that wraps from 0xFFFFFFFF to 0.
- The counter value in the STP cycle SHALL be latched.
- ptm_sof_stamp SHALL update with any valid pulse.
REQ-030 SHALL, without PTM_SNIFF_TIMESTAMP_EN, omit the counter and tie ptm_sof_stamp to 0.

Verification
REQ-031 SHALL verify: STP lane 0; Request, 0x34, code 0x52; END at index 23 -> ptm_req_valid one cycle after END; no other pulse.
REQ-032 SHALL verify: STP lane 1; ResponseD, 0x74, code 0x53; delay 0x00000123; time 0x0011223344556677 -> ptm_rspd_valid; prop_delay 0x123; master_time 0x0011223344556677.
REQ-033 SHALL verify: ResponseD ending in EDB -> no pulse; outputs unchanged.
REQ-034 SHALL verify: Response with END at index 25 -> ptm_err single pulse; ptm_rsp_valid stays 0.
REQ-035 SHALL verify: memory-read TLP (0x00) immediately followed in the same cycle by a Request (END lane 0, STP lane 1) -> exactly one ptm_req_valid.
REQ-036 SHALL verify: reset asserted at index 12 of a ResponseD -> outputs 0 at once; no pulse after release; the next Request is detected.

Source files
------------

// File: rtl/pcie_ptm_tlp_detector.sv
// Sniffs a two-lane PCIe symbol stream and reports PTM Request/Response/ResponseD TLPs.
// Optional macro PTM_SNIFF_TIMESTAMP_EN adds a cycle counter stamped at each STP.
module pcie_ptm_tlp_detector (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [15:0] rx_data_in,
   input  logic [1:0]  rx_ctl_in,
   output logic        ptm_req_valid,
   output logic        ptm_rsp_valid,
   output logic        ptm_rspd_valid,
   output logic [63:0] ptm_master_time,
   output logic [31:0] ptm_prop_delay,
   output logic [31:0] ptm_sof_stamp,
   output logic        ptm_err
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, SKIP} state_t;
   typedef enum logic [1:0] {K_NONE, K_REQ, K_RSP, K_RSPD} kind_t;

   localparam logic [7:0] SYM_STP = 8'hFB;
   localparam logic [7:0] SYM_END = 8'hFD;
   localparam logic [7:0] SYM_EDB = 8'hFE;

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [11:0] idx_q, idx_d;
   logic [7:0]  hdr3_q, hdr3_d;
   logic [31:0] dly_q, dly_d;
   logic [31:0] tlo_q, tlo_d;
   logic [31:0] thi_q, thi_d;
   logic        req_q, req_d, rsp_q, rsp_d, rspd_q, rspd_d, err_q, err_d;
   logic [63:0] master_q, master_d;
   logic [31:0] prop_q, prop_d;
   logic        fired;
   logic [7:0]  sym;
   logic        is_k;
`ifdef PTM_SNIFF_TIMESTAMP_EN
   logic [31:0] cnt_q, cnt_d, stamp_q, stamp_d, sof_q, sof_d;
`endif

   // Each lane is one byte step through the same parser; lane 0 is applied first.
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      idx_d    = idx_q;
      hdr3_d   = hdr3_q;
      dly_d    = dly_q;
      tlo_d    = tlo_q;
      thi_d    = thi_q;
      master_d = master_q;
      prop_d   = prop_q;
      req_d    = 1'b0;
      rsp_d    = 1'b0;
      rspd_d   = 1'b0;
      err_d    = 1'b0;
      fired    = 1'b0;
      sym      = 8'h00;
      is_k     = 1'b0;
`ifdef PTM_SNIFF_TIMESTAMP_EN
      cnt_d    = cnt_q + 32'd1;
      stamp_d  = stamp_q;
      sof_d    = sof_q;
`endif
      for (int l = 0; l < 2; l++) begin
         sym  = rx_data_in[8*l +: 8];
         is_k = rx_ctl_in[l];
         if (is_k && sym == SYM_STP) begin
            if (state_d != IDLE && kind_d != K_NONE && !fired) begin
               err_d = 1'b1;
               fired = 1'b1;
            end
            state_d = HDR;
            kind_d  = K_NONE;
            idx_d   = 12'd1;
`ifdef PTM_SNIFF_TIMESTAMP_EN
            stamp_d = cnt_q;
`endif
         end else if (state_d != IDLE) begin
            if (is_k && sym == SYM_EDB) begin
               state_d = IDLE;
            end else if (is_k && sym == SYM_END) begin
               if (!fired) begin
                  if (kind_d == K_REQ && idx_d == 12'd23) begin
                     req_d = 1'b1;
                  end else if (kind_d == K_RSP && idx_d == 12'd23) begin
                     rsp_d = 1'b1;
                  end else if (kind_d == K_RSPD && idx_d == 12'd31) begin
                     rspd_d   = 1'b1;
                     master_d = {thi_d, tlo_d};
                     prop_d   = dly_d;
                  end else if (kind_d != K_NONE) begin
                     err_d = 1'b1;
                  end
                  fired = req_d | rsp_d | rspd_d | err_d;
`ifdef PTM_SNIFF_TIMESTAMP_EN
                  if (req_d | rsp_d | rspd_d) sof_d = stamp_d;
`endif
               end
               state_d = IDLE;
            end else if (idx_d == 12'hFFF) begin
               // Byte 4095 is the last one a TLP may use; anything else is an overrun.
               if (kind_d != K_NONE && !fired) begin
                  err_d = 1'b1;
                  fired = 1'b1;
               end
               state_d = IDLE;
            end else begin
               if (state_d != SKIP) begin
                  if (idx_d == 12'd3) hdr3_d = sym;
                  if (idx_d == 12'd10) begin
                     if (hdr3_d == 8'h34 && sym == 8'h52)      kind_d = K_REQ;
                     else if (hdr3_d == 8'h34 && sym == 8'h53) kind_d = K_RSP;
                     else if (hdr3_d == 8'h74 && sym == 8'h53) kind_d = K_RSPD;
                     else                                       state_d = SKIP;
                  end
                  if (idx_d >= 12'd15 && idx_d <= 12'd18) dly_d = {dly_d[23:0], sym};
                  if (idx_d >= 12'd19 && idx_d <= 12'd22) tlo_d = {tlo_d[23:0], sym};
                  if (idx_d >= 12'd23 && idx_d <= 12'd26) thi_d = {thi_d[23:0], sym};
                  if (idx_d == 12'd18 && kind_d == K_RSPD) state_d = DATA;
               end
               idx_d = idx_d + 12'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q  <= IDLE;
         kind_q   <= K_NONE;
         idx_q    <= '0;
         hdr3_q   <= '0;
         dly_q    <= '0;
         tlo_q    <= '0;
         thi_q    <= '0;
         master_q <= '0;
         prop_q   <= '0;
         req_q    <= 1'b0;
         rsp_q    <= 1'b0;
         rspd_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         idx_q    <= idx_d;
         hdr3_q   <= hdr3_d;
         dly_q    <= dly_d;
         tlo_q    <= tlo_d;
         thi_q    <= thi_d;
         master_q <= master_d;
         prop_q   <= prop_d;
         req_q    <= req_d;
         rsp_q    <= rsp_d;
         rspd_q   <= rspd_d;
         err_q    <= err_d;
      end
   end

`ifdef PTM_SNIFF_TIMESTAMP_EN
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         cnt_q   <= '0;
         stamp_q <= '0;
         sof_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         stamp_q <= stamp_d;
         sof_q   <= sof_d;
      end
   end
   assign ptm_sof_stamp = sof_q;
`else
   assign ptm_sof_stamp = 32'h0;
`endif

   assign ptm_req_valid   = req_q;
   assign ptm_rsp_valid   = rsp_q;
   assign ptm_rspd_valid  = rspd_q;
   assign ptm_err         = err_q;
   assign ptm_master_time = master_q;
   assign ptm_prop_delay  = prop_q;

endmodule

// File: tb/tb_pcie_ptm_tlp_detector.sv
// Scoreboard bench for pcie_ptm_tlp_detector: TLPs are built as byte lists, expected
// pulses are queued when the tagged symbol is driven and matched by a separate monitor.
module tb_pcie_ptm_tlp_detector;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [15:0] rx_data_in;
   logic [1:0]  rx_ctl_in;
   logic        ptm_req_valid, ptm_rsp_valid, ptm_rspd_valid, ptm_err;
   logic [63:0] ptm_master_time;
   logic [31:0] ptm_prop_delay, ptm_sof_stamp;

   pcie_ptm_tlp_detector dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_data_in(rx_data_in), .rx_ctl_in(rx_ctl_in),
      .ptm_req_valid(ptm_req_valid), .ptm_rsp_valid(ptm_rsp_valid),
      .ptm_rspd_valid(ptm_rspd_valid), .ptm_master_time(ptm_master_time),
      .ptm_prop_delay(ptm_prop_delay), .ptm_sof_stamp(ptm_sof_stamp), .ptm_err(ptm_err)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {bit k; bit [7:0] d; bit tag;} sym_t;
   typedef struct {int ev; int cyc; logic [63:0] mt; logic [31:0] pd; logic [31:0] st;} exp_t;

   sym_t        stream[$];
   exp_t        pend_q[$];
   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   logic [31:0] tb_cnt;
   logic [31:0] cur_stamp = 0, last_sof = 0;
   logic [63:0] model_mt = 0;
   logic [31:0] model_pd = 0;
   bit          abort_pending = 0;
   bit          no_gap = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(posedge clk_in or negedge rst_n_in)
      if (!rst_n_in) tb_cnt <= 0;
      else           tb_cnt <= tb_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic int classify(input logic [7:0] b3, input logic [7:0] code);
      if (b3 == 8'h34 && code == 8'h52) return 1;
      if (b3 == 8'h34 && code == 8'h53) return 2;
      if (b3 == 8'h74 && code == 8'h53) return 3;
      return 0;
   endfunction

   function automatic void push_sym(input bit k, input bit [7:0] d, input bit tag);
      sym_t s;
      s.k = k; s.d = d; s.tag = tag;
      stream.push_back(s);
   endfunction

   function automatic void pad_to_lane(input int lane);
      while ((stream.size() % 2) != lane) push_sym(1'b0, 8'h00, 1'b0);
   endfunction

   function automatic void push_pend(input int ev);
      exp_t e;
      e.ev = ev; e.cyc = 0; e.mt = model_mt; e.pd = model_pd; e.st = 0;
      pend_q.push_back(e);
   endfunction

   // term: 0 END at tidx, 1 EDB at tidx, 2 next STP at tidx, 3 truncated before tidx
   task automatic applyStimulus(input logic [7:0] b3, input logic [7:0] code, input int term,
                                input int tidx, input logic [31:0] pd, input logic [63:0] mt,
                                input int gap);
      int         cls, eidx, ev;
      bit         tag_stp;
      logic [7:0] b;
      cls  = classify(b3, code);
      eidx = (cls == 3) ? 31 : 23;
      tag_stp = abort_pending;
      abort_pending = 0;
      if (!no_gap) for (int g = 0; g < gap; g++) push_sym(1'b0, 8'h00, 1'b0);
      no_gap = 0;
      push_sym(1'b1, 8'hFB, tag_stp);
      for (int i = 1; i < tidx; i++) begin
         b = 8'($urandom);
         if (i == 3) b = b3;
         else if (i == 10) b = code;
         else if (i >= 15 && i <= 18) b = pd[8*(18-i) +: 8];
         else if (i >= 19 && i <= 22) b = mt[8*(22-i) +: 8];
         else if (i >= 23 && i <= 26) b = mt[32 + 8*(26-i) +: 8];
         push_sym(1'b0, b, 1'b0);
      end
      ev = 0;
      if (term == 0) begin
         if (cls != 0 && tidx > 10) ev = (tidx == eidx) ? cls : 4;
         if (ev == 3) begin
            model_mt = mt;
            model_pd = pd;
         end
         if (ev != 0) push_pend(ev);
         push_sym(1'b1, 8'hFD, ev != 0);
      end else if (term == 1) begin
         push_sym(1'b1, 8'hFE, 1'b0);
      end else if (term == 2) begin
         no_gap = 1;
         if (cls != 0 && tidx > 10) begin
            push_pend(4);
            abort_pending = 1;
         end
      end
   endtask

   task automatic drive_stream();
      sym_t s;
      exp_t e;
      logic [15:0] d;
      logic [1:0]  k;
      while (stream.size() > 0) begin
         @(posedge clk_in);
         #1;
         for (int l = 0; l < 2; l++) begin
            if (stream.size() > 0) s = stream.pop_front();
            else begin s.k = 0; s.d = 0; s.tag = 0; end
            d[8*l +: 8] = s.d;
            k[l] = s.k;
            if (s.tag && pend_q.size() > 0) begin
               e = pend_q.pop_front();
               e.cyc = cyc + 1;
               if (e.ev != 4) last_sof = cur_stamp;
               e.st = last_sof;
               exp_q.push_back(e);
            end
            if (s.k && s.d == 8'hFB) begin
`ifdef PTM_SNIFF_TIMESTAMP_EN
               cur_stamp = tb_cnt;
`else
               cur_stamp = 0;
`endif
            end
         end
         rx_data_in = d;
         rx_ctl_in  = k;
      end
      @(posedge clk_in);
      #1;
      rx_data_in = 16'h0;
      rx_ctl_in  = 2'b00;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk_in);
      @(negedge clk_in);
      chk("drain_pending", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic checkOutput(input string tag);
      chk({tag, "_req"},  64'(ptm_req_valid), 64'd0);
      chk({tag, "_rsp"},  64'(ptm_rsp_valid), 64'd0);
      chk({tag, "_rspd"}, 64'(ptm_rspd_valid), 64'd0);
      chk({tag, "_err"},  64'(ptm_err), 64'd0);
      chk({tag, "_mt"},   ptm_master_time, 64'd0);
      chk({tag, "_pd"},   64'(ptm_prop_delay), 64'd0);
      chk({tag, "_sof"},  64'(ptm_sof_stamp), 64'd0);
   endtask

   // Monitor: every pulse must match the next queued expectation, in type, cycle and data.
   always @(negedge clk_in) begin
      int   n, ev;
      exp_t e;
      if (rst_n_in === 1'b1) begin
         n = int'(ptm_req_valid) + int'(ptm_rsp_valid) + int'(ptm_rspd_valid) + int'(ptm_err);
         if (n > 0) begin
            chk("one_pulse", 64'(n), 64'd1);
            ev = ptm_rspd_valid ? 3 : ptm_rsp_valid ? 2 : ptm_req_valid ? 1 : 4;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_pulse actual=type%0d@%0d required=none", ev, cyc);
            end else begin
               e = exp_q.pop_front();
               chk("pulse_type", 64'(ev), 64'(e.ev));
               chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
               chk("master_time", ptm_master_time, e.mt);
               chk("prop_delay", 64'(ptm_prop_delay), 64'(e.pd));
               chk("sof_stamp", 64'(ptm_sof_stamp), 64'(e.st));
            end
         end
      end
   end

   initial begin
      int          t, r, cls, eidx, tidx, term;
      logic [7:0]  b3, code;
      logic [7:0]  b3_tab[5];
      logic [7:0]  code_tab[4];
      b3_tab   = '{8'h00, 8'h20, 8'h34, 8'h74, 8'h44};
      code_tab = '{8'h52, 8'h53, 8'h00, 8'h7F};
      rst_n_in   = 1'b0;
      rx_data_in = 16'h0;
      rx_ctl_in  = 2'b00;
      #23;
      checkOutput("reset");
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // Directed: Request lane 0, ResponseD lane 1, ResponseD+EDB, bad Response END,
      // memory read sharing its END cycle with a Request STP.
      pad_to_lane(0);
      applyStimulus(8'h34, 8'h52, 0, 23, $urandom, {$urandom, $urandom}, 0);
      applyStimulus(8'h00, 8'h00, 0, 30, 0, 0, 2);
      pad_to_lane(1);
      applyStimulus(8'h74, 8'h53, 0, 31, 32'h0000_0123, 64'h0011_2233_4455_6677, 0);
      applyStimulus(8'h74, 8'h53, 1, 29, $urandom, {$urandom, $urandom}, 1);
      applyStimulus(8'h34, 8'h53, 0, 25, $urandom, {$urandom, $urandom}, 2);
      pad_to_lane(1);
      applyStimulus(8'h00, 8'h00, 0, 23, $urandom, {$urandom, $urandom}, 0);
      applyStimulus(8'h34, 8'h52, 0, 23, $urandom, {$urandom, $urandom}, 0);
      drive_stream();
      drain();
      chk("edb_hold_mt", ptm_master_time, 64'h0011_2233_4455_6677);
      chk("edb_hold_pd", 64'(ptm_prop_delay), 64'h123);

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         t = $urandom_range(0, 4);
         case (t)
            0: begin b3 = 8'h34; code = 8'h52; end
            1: begin b3 = 8'h34; code = 8'h53; end
            2: begin b3 = 8'h74; code = 8'h53; end
            3: begin b3 = 8'h00; code = 8'($urandom); end
            default: begin
               b3   = b3_tab[$urandom_range(0, 4)];
               code = code_tab[$urandom_range(0, 3)];
            end
         endcase
         cls  = classify(b3, code);
         eidx = (cls == 3) ? 31 : 23;
         r    = (n == 79) ? 0 : $urandom_range(0, 9);
         if (r <= 5) begin
            term = 0;
            tidx = (cls != 0) ? eidx : $urandom_range(11, 40);
         end else if (r == 6) begin
            term = 0;
            do tidx = $urandom_range(5, 40); while (tidx == eidx);
         end else if (r == 7) begin
            term = 1;
            tidx = $urandom_range(3, 35);
         end else begin
            term = 2;
            tidx = $urandom_range(2, 35);
         end
         applyStimulus(b3, code, term, tidx, $urandom, {$urandom, $urandom},
                       $urandom_range(0, 2));
      end
      drive_stream();
      drain();
      chk("hold_mt", ptm_master_time, model_mt);
      chk("hold_pd", 64'(ptm_prop_delay), 64'(model_pd));

      // Reset in the middle of a ResponseD (bytes 0..12 only)
      pad_to_lane(0);
      applyStimulus(8'h74, 8'h53, 3, 13, $urandom, {$urandom, $urandom}, 0);
      drive_stream();
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("async_reset");
      model_mt  = 0;
      model_pd  = 0;
      last_sof  = 0;
      cur_stamp = 0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (10) @(posedge clk_in);
      applyStimulus(8'h34, 8'h52, 0, 23, $urandom, {$urandom, $urandom}, 1);
      drive_stream();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
